// File: rtl/sram_responder_if.sv
// Memory-side request/response bundle between a requester (master) and the
// SRAM stand-in (slave).
interface sram_responder_if #(
   parameter int unsigned ADDR_W = 18
);
   logic [ADDR_W-1:0] SRAM_address;
   logic [15:0]       SRAM_write_data;
   logic              SRAM_we_n;
   logic [15:0]       SRAM_read_data;
   logic              SRAM_ready;
   logic [31:0]       read_count;
   logic [31:0]       write_count;

   modport master (
      output SRAM_address, SRAM_write_data, SRAM_we_n,
      input  SRAM_read_data, SRAM_ready, read_count, write_count
   );

   modport slave (
      input  SRAM_address, SRAM_write_data, SRAM_we_n,
      output SRAM_read_data, SRAM_ready, read_count, write_count
   );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the 16-bit external SRAM path: clear sweep after reset, two-cycle read latency.
// Define SRAM_RESP_FAULT_EN to force bit FAULT_BIT to 1 on reads of FAULT_ADDR.
module sram_responder #(
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned FAULT_ADDR = 0,
   parameter int unsigned FAULT_BIT  = 0
) (
   input  logic              Clock,
   input  logic              Resetn,
   sram_responder_if.slave   bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef SRAM_RESP_FAULT_EN
   localparam bit FaultEn = 1'b1;
`else
   localparam bit FaultEn = 1'b0;
`endif
   localparam logic [15:0]       FaultMask = FaultEn ? (16'(1) << FAULT_BIT) : '0;
   localparam logic [ADDR_W-1:0] FaultAddr = ADDR_W'(FAULT_ADDR);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] clr_q;
   logic [ADDR_W-1:0] s1_addr_q;
   logic              s1_we_n_q;
   logic              s1_valid_q;
   logic [15:0]       s1_data_q;
   logic [15:0]       rd_q;
   logic [15:0]       rd_d;
   logic              ready_q;
   logic [31:0]       rc_q;
   logic [31:0]       wc_q;

   logic [15:0]       mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   // The clear sweep owns the array port until ready; afterwards only stage-1 writes use it.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = clr_q;
      mem_wdata = '0;
      if (state_q == S_INIT) begin
         mem_we = 1'b1;
      end else if (s1_valid_q && !s1_we_n_q) begin
         mem_we    = 1'b1;
         mem_addr  = s1_addr_q;
         mem_wdata = s1_data_q;
      end
   end

   always_comb begin
      rd_d = mem[s1_addr_q] | ((s1_addr_q == FaultAddr) ? FaultMask : '0);
   end

   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_INIT;
         clr_q      <= '0;
         s1_addr_q  <= '0;
         s1_we_n_q  <= 1'b1;
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
         rd_q       <= '0;
         ready_q    <= 1'b0;
         rc_q       <= '0;
         wc_q       <= '0;
      end else begin
         if (s1_valid_q && s1_we_n_q) begin
            rd_q <= rd_d;
         end
         case (state_q)
            S_INIT: begin
               clr_q      <= clr_q + 1'b1;
               s1_valid_q <= 1'b0;
               if (clr_q == '1) begin
                  state_q <= S_READY;
                  ready_q <= 1'b1;
               end
            end
            S_READY: begin
               s1_addr_q  <= bus.SRAM_address;
               s1_we_n_q  <= bus.SRAM_we_n;
               s1_data_q  <= bus.SRAM_write_data;
               s1_valid_q <= 1'b1;
               if (bus.SRAM_we_n) begin
                  if (rc_q != '1) rc_q <= rc_q + 32'd1;
               end else begin
                  if (wc_q != '1) wc_q <= wc_q + 32'd1;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign bus.SRAM_read_data = rd_q;
   assign bus.SRAM_ready     = ready_q;
   assign bus.read_count     = rc_q;
   assign bus.write_count    = wc_q;
endmodule
